// File: rtl/fp_unpack.sv
// fp_unpack: operand front end of the FP multiplier.
// Splits two packed floats into sign/exponent/significand, classifies them,
// and resolves special-case products for the assembly stage.
// Two registered stages with valid/ready backpressure.
// Optional feature macro: FP_UNPACK_DENORM_EN (keep denormals instead of flushing).
module fp_unpack #(
  parameter int WIDTH = 32,
  parameter int WEXP  = 8,
  parameter int WSIG  = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       roundmode_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WEXP-1:0]  expa,
  output logic [WEXP-1:0]  expb,
  output logic [WSIG:0]    siga,
  output logic [WSIG:0]    sigb,
  output logic             specialcase,
  output logic [WIDTH-2:0] special,
  output logic             specialsigncase,
  output logic             specialsign,
  output logic [1:0]       roundmode
);

  typedef struct packed {
    logic            zero;
    logic            inf;
    logic            nan;
    logic [WEXP-1:0] exp;
    logic [WSIG:0]   sig;
  } op_t;

  localparam logic [WIDTH-2:0] QNAN = {{WEXP{1'b1}}, 1'b1, {(WSIG-1){1'b0}}};
  localparam logic [WIDTH-2:0] INF  = {{WEXP{1'b1}}, {WSIG{1'b0}}};

  // Classify one operand and produce its effective exponent and significand.
  function automatic op_t decode(input logic [WIDTH-1:0] x);
    op_t             o;
    logic [WEXP-1:0] e;
    logic [WSIG-1:0] f;
    e      = x[WIDTH-2 -: WEXP];
    f      = x[WSIG-1:0];
    o.zero = 1'b0;
    o.inf  = 1'b0;
    o.nan  = 1'b0;
    o.exp  = e;
    o.sig  = {1'b1, f};
    if (e == '0) begin
`ifdef FP_UNPACK_DENORM_EN
      if (f == '0) begin
        o.zero = 1'b1;
        o.exp  = '0;
        o.sig  = '0;
      end else begin
        // Denormal: implicit exponent of 1, no hidden bit.
        o.exp = WEXP'(1);
        o.sig = {1'b0, f};
      end
`else
      // Denormals flush to zero together with true zeros.
      o.zero = 1'b1;
      o.exp  = '0;
      o.sig  = '0;
`endif
    end else if (e == '1) begin
      o.inf = (f == '0);
      o.nan = (f != '0);
    end
    return o;
  endfunction

  logic       s1_valid;
  logic       s1_sign;
  logic [1:0] s1_rm;
  op_t        s1_a, s1_b;
  op_t        da, db;

  logic             s2_en, s1_en;
  logic             sp_case, sp_signcase, sp_sign;
  logic [WIDTH-2:0] sp_val;

  // Stage 2 moves when empty or draining; stage 1 moves when it or stage 2 can.
  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = ~s1_valid | ~out_valid | out_ready;

  assign da = decode(a);
  assign db = decode(b);

  // Stage 1: register decoded fields, class flags, sign and rounding mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rm    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= a[WIDTH-1] ^ b[WIDTH-1];
        s1_rm   <= roundmode_in;
        s1_a    <= da;
        s1_b    <= db;
      end
    end
  end

  // Resolve the special-case product from stage-1 class flags, highest priority first.
  always_comb begin
    sp_case     = 1'b0;
    sp_val      = '0;
    sp_signcase = 1'b0;
    sp_sign     = 1'b0;
    if (s1_a.nan || s1_b.nan || (s1_a.inf && s1_b.zero) || (s1_a.zero && s1_b.inf)) begin
      sp_case     = 1'b1;
      sp_val      = QNAN;
      sp_signcase = 1'b1;
      sp_sign     = 1'b0;
    end else if (s1_a.inf || s1_b.inf) begin
      sp_case = 1'b1;
      sp_val  = INF;
    end else if (s1_a.zero || s1_b.zero) begin
      sp_case = 1'b1;
      sp_val  = '0;
    end
  end

  // Stage 2: register resolved special fields and forward the operand fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      sign            <= 1'b0;
      expa            <= '0;
      expb            <= '0;
      siga            <= '0;
      sigb            <= '0;
      specialcase     <= 1'b0;
      special         <= '0;
      specialsigncase <= 1'b0;
      specialsign     <= 1'b0;
      roundmode       <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign            <= s1_sign;
        expa            <= s1_a.exp;
        expb            <= s1_b.exp;
        siga            <= s1_a.sig;
        sigb            <= s1_b.sig;
        specialcase     <= sp_case;
        special         <= sp_val;
        specialsigncase <= sp_signcase;
        specialsign     <= sp_sign;
        roundmode       <= s1_rm;
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack.sv
// Directed self-checking bench for fp_unpack.
module tb_fp_unpack;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic [1:0]  roundmode_in;
  logic        out_valid, out_ready;
  logic        sign;
  logic [7:0]  expa, expb;
  logic [23:0] siga, sigb;
  logic        specialcase;
  logic [30:0] special;
  logic        specialsigncase, specialsign;
  logic [1:0]  roundmode;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [30:0] QNAN = 31'h7FC00000;
  localparam logic [30:0] INF  = 31'h7F800000;

  fp_unpack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .roundmode_in(roundmode_in), .out_valid(out_valid),
    .out_ready(out_ready), .sign(sign), .expa(expa), .expb(expb),
    .siga(siga), .sigb(sigb), .specialcase(specialcase), .special(special),
    .specialsigncase(specialsigncase), .specialsign(specialsign),
    .roundmode(roundmode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pair with out_ready high; return positioned #1 after the second edge.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] rm);
    a = va; b = vb; roundmode_in = rm; in_valid = 1'b1;
    #1;
    chk("send_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat1_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat2_out_valid", {31'b0, out_valid}, 32'd1);
  endtask

  logic [31:0] pa [4];
  logic [7:0]  pexp [4];
  int k, got;
  logic acc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; roundmode_in = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_expa", {24'b0, expa}, 32'd0);
    chk("rst_special", {1'b0, special}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 3.0 x 2.0
    send(32'h40400000, 32'h40000000, 2'd2);
    chk("norm_expa", {24'b0, expa}, 32'h80);
    chk("norm_expb", {24'b0, expb}, 32'h80);
    chk("norm_siga", {8'b0, siga}, 32'hC00000);
    chk("norm_sigb", {8'b0, sigb}, 32'h800000);
    chk("norm_sign", {31'b0, sign}, 32'd0);
    chk("norm_spcase", {31'b0, specialcase}, 32'd0);
    chk("norm_rm", {30'b0, roundmode}, 32'd2);
    @(posedge clk); #1;
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // inf x 0
    send(32'h7F800000, 32'h00000000, 2'd1);
    chk("infz_spcase", {31'b0, specialcase}, 32'd1);
    chk("infz_special", {1'b0, special}, {1'b0, QNAN});
    chk("infz_ssc", {31'b0, specialsigncase}, 32'd1);
    chk("infz_ss", {31'b0, specialsign}, 32'd0);

    // NaN x 1.0
    send(32'h7FC00001, 32'h3F800000, 2'd0);
    chk("nan_spcase", {31'b0, specialcase}, 32'd1);
    chk("nan_special", {1'b0, special}, {1'b0, QNAN});
    chk("nan_ssc", {31'b0, specialsigncase}, 32'd1);
    chk("nan_ss", {31'b0, specialsign}, 32'd0);

    // -inf x 2.0
    send(32'hFF800000, 32'h40000000, 2'd3);
    chk("inf_spcase", {31'b0, specialcase}, 32'd1);
    chk("inf_special", {1'b0, special}, {1'b0, INF});
    chk("inf_ssc", {31'b0, specialsigncase}, 32'd0);
    chk("inf_sign", {31'b0, sign}, 32'd1);

    // denormal x 1.0
    send(32'h00000001, 32'h3F800000, 2'd0);
`ifdef FP_UNPACK_DENORM_EN
    chk("dn_expa", {24'b0, expa}, 32'd1);
    chk("dn_siga", {8'b0, siga}, 32'h000001);
    chk("dn_spcase", {31'b0, specialcase}, 32'd0);
`else
    chk("dn_spcase", {31'b0, specialcase}, 32'd1);
    chk("dn_special", {1'b0, special}, 32'd0);
`endif

    // Backpressure: 4 pairs, out_ready low for the first 5 cycles
    for (int i = 0; i < 4; i++) begin
      pexp[i] = 8'h81 + 8'(i);
      pa[i]   = {1'b0, pexp[i], 23'h0};
    end
    @(posedge clk); #1;
    k = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (k < 4);
      a = (k < 4) ? pa[k] : 32'h0;
      b = 32'h3F800000;
      #1;
      if (cyc < 2) chk("bp_in_ready_hi", {31'b0, in_ready}, 32'd1);
      if (cyc >= 2 && cyc < 5) begin
        chk("bp_in_ready_lo", {31'b0, in_ready}, 32'd0);
        chk("bp_stable_expa", {24'b0, expa}, 32'h81);
        chk("bp_stall_valid", {31'b0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        chk("bp_order_expa", {24'b0, expa}, {24'b0, pexp[got]});
        got++;
      end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_count", got, 32'd4);
    chk("bp_accepted", k, 32'd4);
    chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
